// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared constants and state type for the PWM update scheduler
package pwm_pkg;

    localparam logic [2:0] ADDR_TOP  = 3'd4;
    localparam logic [2:0] ADDR_CTRL = 3'd5;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_COMMIT = 1;
    localparam int CTRL_INV    = 2;

    // All-ones; sliced to the counter width where used so TOP defaults to full range
    localparam logic [31:0] DEFAULT_TOP = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_RUN      = 2'd1,
        ST_PENDING  = 2'd2
    } state_t;

endpackage

// File: rtl/pwm_channel.sv
// rtl/pwm_channel.sv - one PWM channel: active duty register, compare and output flop
module pwm_channel #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] duty_shadow,
    input  logic [CNT_W-1:0] cnt,
    input  logic             enable,
    input  logic             inv,
    output logic             pwm
);

    logic [CNT_W-1:0] duty_active;

    // Active duty only changes when the scheduler commits the shadow set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_active <= '0;
        end else if (load) begin
            duty_active <= duty_shadow;
        end
    end

    // Output lags the counter by one cycle; held low (no inversion) while disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm <= 1'b0;
        end else begin
            pwm <= enable ? ((cnt < duty_active) ^ inv) : 1'b0;
        end
    end

endmodule

// File: rtl/pwm_update_scheduler.sv
// rtl/pwm_update_scheduler.sv - period counter, shadow registers and boundary-aligned commit FSM
module pwm_update_scheduler
    import pwm_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [2:0]        wr_addr,
    input  logic [CNT_W-1:0]  wr_data,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              period_start,
    output logic              commit_pending,
    output logic              running
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] top_active;
    logic [CNT_W-1:0] top_shadow;
    logic [CNT_W-1:0] duty_shadow [NUM_CH];
    logic             inv_shadow;
    logic             inv_active;

    logic wr_fire;
    logic ctrl_wr;
    logic wrap;
    logic apply_now;

    assign commit_pending = (state == ST_PENDING);
    assign wr_ready       = !commit_pending;
    assign running        = (state != ST_DISABLED);

    assign wr_fire = wr_valid && wr_ready;
    assign ctrl_wr = wr_fire && (wr_addr == ADDR_CTRL);
    assign wrap    = (cnt == top_active);

    // Shadows go active either immediately (commit while disabled) or on the wrap edge of a pending period
    assign apply_now = ((state == ST_DISABLED) && ctrl_wr && wr_data[CTRL_COMMIT]) ||
                       ((state == ST_PENDING) && wrap);

    // Host writes land in the shadow set; unmapped addresses are accepted and dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                duty_shadow[i] <= '0;
            end
            top_shadow <= DEFAULT_TOP[CNT_W-1:0];
            inv_shadow <= 1'b0;
        end else if (wr_fire) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_addr == 3'(i)) begin
                    duty_shadow[i] <= wr_data;
                end
            end
            if (wr_addr == ADDR_TOP) begin
                top_shadow <= wr_data;
            end
            if (wr_addr == ADDR_CTRL) begin
                inv_shadow <= wr_data[CTRL_INV];
            end
        end
    end

    // Controller FSM with the shared period counter and the shared active TOP/INV
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_DISABLED;
            cnt        <= '0;
            top_active <= DEFAULT_TOP[CNT_W-1:0];
            inv_active <= 1'b0;
        end else begin
            case (state)
                ST_DISABLED: begin
                    cnt <= '0;
                    if (ctrl_wr) begin
                        if (wr_data[CTRL_COMMIT]) begin
                            top_active <= top_shadow;
                            inv_active <= wr_data[CTRL_INV];
                        end
                        if (wr_data[CTRL_EN]) begin
                            state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    cnt <= wrap ? '0 : cnt + CNT_W'(1);
                    if (ctrl_wr) begin
                        if (!wr_data[CTRL_EN]) begin
                            state <= ST_DISABLED;
                            cnt   <= '0;
                        end else if (wr_data[CTRL_COMMIT]) begin
                            state <= ST_PENDING;
                        end
                    end
                end
                ST_PENDING: begin
                    if (wrap) begin
                        cnt        <= '0;
                        top_active <= top_shadow;
                        inv_active <= inv_shadow;
                        state      <= ST_RUN;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_DISABLED;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Period marker aligned with the output cycle that reflects count 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_start <= 1'b0;
        end else begin
            period_start <= running && (cnt == '0);
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        pwm_channel #(.CNT_W(CNT_W)) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .load        (apply_now),
            .duty_shadow (duty_shadow[i]),
            .cnt         (cnt),
            .enable      (running),
            .inv         (inv_active),
            .pwm         (pwm_out[i])
        );
    end

endmodule
